// File: rtl/mag_operand_feeder.sv
// mag_operand_feeder: operand FIFO that presents one x/y pair per fixed-length magnitude-core frame
module mag_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int FRAME_LEN = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic [7:0]               in_x,
  input  logic [7:0]               in_y,
  output logic                     in_ready,
  output logic [7:0]               op_x,
  output logic [7:0]               op_y,
  output logic                     op_live,
  output logic                     frame_start,
  output logic                     res_strobe,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   mem [DEPTH];
  logic          res_tag, wrap, push, pop, drop;
  always_comb begin
    wrap = ena && phase == LAST;
    in_ready = fifo_count != FULL;
    push = ena && in_valid && in_ready;
    drop = ena && in_valid && !in_ready;
    pop = wrap && fifo_count != '0;
    frame_start = phase == '0;
    res_strobe = frame_start && res_tag;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {in_x, in_y};
  // pop and full are both judged on pre-edge occupancy, so a push on the pop edge waits a frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      op_x <= '0;
      op_y <= '0;
      op_live <= 1'b0;
      res_tag <= 1'b0;
      drop_cnt <= '0;
    end else if (ena) begin
      phase <= wrap ? '0 : phase + PW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (wrap) begin
        res_tag <= op_live;
        op_live <= pop;
        {op_x, op_y} <= pop ? mem[rd_ptr] : 16'h0;
      end
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule
